// File: rtl/vga_capture.sv
// VGA pixel capture into an AXI-Stream FIFO.
// Syncs are registered, timing is recovered from sync trailing edges, and active pixels are buffered.
module vga_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        pix_ce,
  input  logic        vsync,
  input  logic        hsync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        pix_tvalid,
  input  logic        pix_tready,
  output logic [11:0] pix_tdata,
  output logic        pix_tlast,
  output logic        pix_tuser,
  output logic        sof,
  output logic        overflow
);

  localparam int HW = $clog2(H_BP + H_ACTIVE + 1);
  localparam int VW = $clog2(V_BP + V_ACTIVE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_START = HW'(H_BP);
  localparam logic [HW-1:0] H_END   = HW'(H_BP + H_ACTIVE);
  localparam logic [HW-1:0] H_LAST  = HW'(H_BP + H_ACTIVE - 1);
  localparam logic [VW-1:0] V_START = VW'(V_BP);
  localparam logic [VW-1:0] V_END   = VW'(V_BP + V_ACTIVE);

  localparam logic [1:0] SEEK    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DROP    = 2'd2;

  logic          ce_q, vs_q, hs_q;
  logic [11:0]   rgb_q;
  logic          vs_prev, hs_prev, primed;
  logic          h_edge, v_edge;
  logic [HW-1:0] hcnt, h_now;
  logic [VW-1:0] vcnt, v_now;
  logic          active, s_tuser, s_tlast;
  logic [1:0]    state, state_nx;

  logic [FIFO_DEPTH-1:0][13:0] mem;
  logic [AW:0]   wptr, rptr;
  logic          full, empty, rd_en, wr_try, wr_en, drop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ce_q  <= 1'b0;
      vs_q  <= 1'b0;
      hs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      ce_q  <= pix_ce;
      vs_q  <= vsync;
      hs_q  <= hsync;
      rgb_q <= {b, g, r};
    end
  end

  // History is only valid once one strobed sample has been seen; this keeps
  // the cleared input registers from looking like a sync trailing edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vs_prev <= 1'b0;
      hs_prev <= 1'b0;
      primed  <= 1'b0;
    end else if (ce_q) begin
      vs_prev <= vs_q;
      hs_prev <= hs_q;
      primed  <= 1'b1;
    end
  end

  assign h_edge = ce_q && primed && hs_q && !hs_prev;
  assign v_edge = ce_q && primed && vs_q && !vs_prev;

  // h_now/v_now are the counter values that belong to the current sample.
  always_comb begin
    h_now = hcnt;
    v_now = vcnt;
    if (ce_q) begin
      if (h_edge)             h_now = '0;
      else if (hcnt != H_END) h_now = hcnt + 1'b1;
      if (v_edge)                       v_now = '0;
      else if (h_edge && vcnt != V_END) v_now = vcnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_now;
      vcnt <= v_now;
    end
  end

  assign active  = ce_q && (h_now >= H_START) && (h_now < H_END) &&
                   (v_now >= V_START) && (v_now < V_END);
  assign s_tuser = (h_now == H_START) && (v_now == V_START);
  assign s_tlast = (h_now == H_LAST);

  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pix_tvalid = !empty;
  assign rd_en      = pix_tvalid && pix_tready;
  assign wr_try     = (state == CAPTURE) && active;
  assign wr_en      = wr_try && (!full || rd_en);
  assign drop       = wr_try && full && !rd_en;

  assign {pix_tuser, pix_tlast, pix_tdata} = mem[rptr[AW-1:0]];

  always_comb begin
    state_nx = state;
    case (state)
      SEEK:    if (v_edge) state_nx = CAPTURE;
      CAPTURE: if (drop)   state_nx = DROP;
      DROP:    if (v_edge) state_nx = CAPTURE;
      default: state_nx = SEEK;
    endcase
  end

  // Storage is cleared on reset so the output beat fields read zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      state    <= SEEK;
      sof      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= {s_tuser, s_tlast, rgb_q};
        wptr              <= wptr + 1'b1;
      end
      if (rd_en) rptr <= rptr + 1'b1;
      state <= state_nx;
      sof   <= wr_en && s_tuser;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed and randomized checks of vga_capture against a transaction-level
// frame/FIFO model; inputs change and outputs are sampled on the falling edge.
module tb_vga_capture;
  localparam int HA = 4, HB = 2, VA = 3, VB = 1, FD = 4;
  localparam int M_SEEK = 0, M_CAP = 1, M_DROP = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        pix_ce = 1'b1;
  logic        vsync = 1'b1, hsync = 1'b1;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic        pix_tvalid, pix_tlast, pix_tuser, sof, overflow;
  logic        pix_tready = 1'b1;
  logic [11:0] pix_tdata;

  vga_capture #(.H_ACTIVE(HA), .H_BP(HB), .V_ACTIVE(VA), .V_BP(VB), .FIFO_DEPTH(FD)) dut (
    .aclk(aclk), .aresetn(aresetn), .pix_ce(pix_ce), .vsync(vsync), .hsync(hsync),
    .r(r), .g(g), .b(b), .pix_tvalid(pix_tvalid), .pix_tready(pix_tready),
    .pix_tdata(pix_tdata), .pix_tlast(pix_tlast), .pix_tuser(pix_tuser),
    .sof(sof), .overflow(overflow));

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic vedge; logic act; logic tuser; logic tlast;
    logic [1:0] row; logic [1:0] col; logic [11:0] data;
  } samp_t;
  typedef struct packed { logic tuser; logic tlast; logic [11:0] data; } beat_t;

  beat_t exp_q[$];
  samp_t pend;
  int    mode_m = M_SEEK;
  logic  exp_ovf = 1'b0, exp_sof = 1'b0;
  int    errors = 0, checks = 0;
  int    rdy_mode = 0, stepn = 0;
  int    dut_beats = 0, sof_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel-clock step: compare outputs against the model, advance the
  // model by one transfer/write opportunity, then present the next sample.
  task automatic step(input logic vs, input logic hs, input samp_t s);
    logic rd, full;
    beat_t bt;
    @(negedge aclk);
    if (rdy_mode == 3 && pend.act && pend.row == 2'd1 && pend.col == 2'd0) rdy_mode = 0;
    case (rdy_mode)
      1:       pix_tready = 1'b0;
      2:       pix_tready = (stepn % 4 == 0) || (stepn % 4 == 3);
      3:       pix_tready = 1'b0;
      default: pix_tready = 1'b1;
    endcase
    chk("tvalid", pix_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("tdata", pix_tdata, exp_q[0].data);
      chk("tlast", pix_tlast, exp_q[0].tlast);
      chk("tuser", pix_tuser, exp_q[0].tuser);
    end
    chk("overflow", overflow, exp_ovf);
    chk("sof", sof, exp_sof);
    if (sof === 1'b1) sof_cnt++;
    if (pix_tvalid === 1'b1 && pix_tready) dut_beats++;
    full = (exp_q.size() >= FD);
    rd   = pix_tready && (exp_q.size() != 0);
    if (rd) bt = exp_q.pop_front();
    exp_sof = 1'b0;
    if (mode_m == M_CAP && pend.act) begin
      if (full && !rd) begin
        mode_m  = M_DROP;
        exp_ovf = 1'b1;
      end else begin
        exp_q.push_back({pend.tuser, pend.tlast, pend.data});
        exp_sof = pend.tuser;
      end
    end
    if (pend.vedge) mode_m = M_CAP;
    vsync = vs;
    hsync = hs;
    {b, g, r} = s.data;
    pend = s;
    stepn++;
  endtask

  task automatic idle(input int n);
    samp_t s;
    for (int i = 0; i < n; i++) begin
      s = '0;
      s.data = 12'($urandom);
      step(1'b1, 1'b1, s);
    end
  endtask

  // Line = 2 samples of hsync low, then nhigh samples; the first high sample
  // is the trailing edge, active columns follow HB samples after it.
  task automatic line(input int row, input bit patt, input int nhigh);
    samp_t s;
    int col;
    for (int k = 0; k < 2; k++) begin
      s = '0;
      s.data = 12'($urandom);
      step(1'b1, 1'b0, s);
    end
    for (int k = 0; k < nhigh; k++) begin
      col = k - HB;
      s = '0;
      s.data = 12'($urandom);
      if (row >= 0 && col >= 0 && col < HA) begin
        s.act   = 1'b1;
        s.tuser = (row == 0 && col == 0);
        s.tlast = (col == HA - 1);
        s.row   = 2'(row);
        s.col   = 2'(col);
        if (patt) s.data = 12'(row * HA + col);
      end
      step(1'b1, 1'b1, s);
    end
  endtask

  task automatic vsync_pulse();
    samp_t s;
    s = '0;
    step(1'b0, 1'b1, s);
    step(1'b0, 1'b1, s);
    s.vedge = 1'b1;
    step(1'b1, 1'b1, s);
  endtask

  task automatic frame(input bit patt);
    vsync_pulse();
    for (int rw = 0; rw < VA; rw++) line(rw, patt, 8);
    line(-1, 1'b0, 8);
  endtask

  task automatic reset_outputs_check();
    chk("rst_tvalid", pix_tvalid, 0);
    chk("rst_tdata", pix_tdata, 0);
    chk("rst_tlast", pix_tlast, 0);
    chk("rst_tuser", pix_tuser, 0);
    chk("rst_sof", sof, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 reset_outputs_check();
    exp_q.delete();
    mode_m  = M_SEEK;
    pend    = '0;
    exp_ovf = 1'b0;
    exp_sof = 1'b0;
    vsync = 1'b1;
    hsync = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  int b0, s0;

  initial begin
    pend = '0;
    repeat (3) @(negedge aclk);
    reset_outputs_check();
    aresetn = 1'b1;
    idle(4);

    // lines without any vsync edge must produce nothing
    b0 = dut_beats;
    for (int i = 0; i < 4; i++) line(-1, 1'b0, 8);
    idle(4);
    chk("no_vsync_beats", dut_beats - b0, 0);

    // basic frame, pixel = row*4+col
    b0 = dut_beats; s0 = sof_cnt;
    frame(1'b1);
    idle(6);
    chk("basic_beats", dut_beats - b0, 12);
    chk("basic_sof", sof_cnt - s0, 1);

    // backpressure: fifo fills, rest of frame dropped
    rdy_mode = 1;
    b0 = dut_beats;
    frame(1'b0);
    idle(4);
    chk("bp_beats", dut_beats - b0, 0);
    chk("bp_overflow", overflow, 1);
    chk("bp_tvalid", pix_tvalid, 1);
    rdy_mode = 0;
    b0 = dut_beats;
    idle(3);
    frame(1'b0);
    idle(6);
    chk("bp_recover_beats", dut_beats - b0, 16);
    chk("bp_overflow_sticky", overflow, 1);

    do_reset();
    idle(4);

    // stall pattern 1,0,0,1
    rdy_mode = 2;
    b0 = dut_beats;
    frame(1'b0);
    idle(12);
    rdy_mode = 0;
    idle(4);
    chk("stall_beats", dut_beats - b0, 12);

    // full fifo with simultaneous read accepts the write
    rdy_mode = 3;
    b0 = dut_beats;
    frame(1'b0);
    idle(8);
    chk("fullrd_overflow", overflow, 0);
    chk("fullrd_beats", dut_beats - b0, 12);

    // async reset mid-line with three beats queued
    rdy_mode = 1;
    vsync_pulse();
    line(0, 1'b0, 6);
    chk("pre_reset_tvalid", pix_tvalid, 1);
    do_reset();
    rdy_mode = 0;
    b0 = dut_beats;
    idle(3);
    line(-1, 1'b0, 8);
    line(-1, 1'b0, 8);
    chk("post_reset_quiet", dut_beats - b0, 0);
    frame(1'b0);
    idle(6);
    chk("post_reset_frame", dut_beats - b0, 12);
    chk("leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_BP, default 48, meaning pixel-enable cycles from the hsync trailing edge to the first active pixel.
REQ-003 The block SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-004 The block SHALL have parameter V_BP, default 33, meaning lines from the vsync trailing edge to the first active line.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 16 (power of 2, >=4), meaning output FIFO entries.
REQ-006 The block SHALL have ports: aclk  in  1  sole clock; aresetn  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have ports: pix_ce  in  1  pixel sample strobe; vsync, hsync  in  1 each  active-low syncs, synchronous to aclk; r, g, b  in  4 each  colour.
REQ-008 The block SHALL have ports: pix_tvalid  out  1; pix_tready  in  1; pix_tdata  out  12  {b,g,r} with r in [3:0]; pix_tlast  out  1  end of line; pix_tuser  out  1  start of frame.
REQ-009 The block SHALL have ports: sof  out  1  one-cycle frame-start pulse; overflow  out  1  sticky FIFO overrun flag.

Function
REQ-010 All inputs except aclk/aresetn SHALL be registered once, and edges SHALL be detected on registered values only on pix_ce cycles.
REQ-011 The hsync trailing edge (0->1) SHALL clear hcnt to 0; hcnt SHALL otherwise increment on each pix_ce, saturating at H_BP+H_ACTIVE.
REQ-012 The vsync trailing edge SHALL clear vcnt to 0; each hsync trailing edge SHALL otherwise increment vcnt, saturating at V_BP+V_ACTIVE.
REQ-013 A sample SHALL be active when H_BP<=hcnt<H_BP+H_ACTIVE and V_BP<=vcnt<V_BP+V_ACTIVE, both evaluated on the pix_ce cycle.
REQ-014 Each active sample SHALL carry tuser=1 only at column 0 of line 0, and tlast=1 only at column H_ACTIVE-1.
REQ-015 The FSM SHALL have states SEEK, CAPTURE and DROP; reset SHALL enter SEEK.
REQ-016 SEEK SHALL write nothing and SHALL go to CAPTURE on a vsync trailing edge.
REQ-017 CAPTURE SHALL write every active sample to the FIFO.
REQ-018 CAPTURE SHALL go to DROP when an active sample arrives with the FIFO full; that sample is discarded and overflow is set.
REQ-019 DROP SHALL write nothing and SHALL go to CAPTURE on the next vsync trailing edge.
REQ-020 sof SHALL pulse for one aclk cycle when a tuser=1 sample is written.
REQ-021 A vsync trailing edge in CAPTURE mid-frame SHALL restart counting without flushing the FIFO; a partial line SHALL NOT receive a forced tlast.
REQ-022 Latency: with the FIFO empty and pix_tready=1, pix_tvalid SHALL assert 2 aclk cycles after the input sample cycle.
REQ-023 Output SHALL follow AXI-Stream rules: data/tlast/tuser held stable while tvalid=1 and tready=0; transfer on tvalid&tready.
REQ-024 The FIFO SHALL accept a write and a read in the same cycle when full; the write SHALL succeed because the read frees a slot.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty derived from an extra pointer bit.

Reset
REQ-026 On aresetn=0, asynchronously, the block SHALL set pix_tvalid=0, pix_tlast=0, pix_tuser=0, pix_tdata=0, sof=0 and overflow=0, and SHALL clear the FIFO, hcnt, vcnt and input registers.
REQ-027 Reset mid-frame SHALL discard all buffered pixels, and capture SHALL restart only after a new vsync trailing edge.
REQ-028 overflow SHALL be cleared only by reset.

Verification (H_ACTIVE=4, H_BP=2, V_ACTIVE=3, V_BP=1, FIFO_DEPTH=4, pix_ce=1 always)
REQ-029 Basic frame: one frame with pixel value = row*4+col and tready=1 -> 12 beats, tuser on beat 0 only, tlast on beats 3/7/11, tdata matches, one sof pulse.
REQ-030 No vsync after reset: lines only, no vsync edge -> zero beats, FSM remains in SEEK.
REQ-031 Backpressure: tready=0 for whole frame -> 4 beats buffered, overflow=1, FSM in DROP; release tready, next frame -> 4 stale beats then 12 fresh beats starting with tuser=1.
REQ-032 Stall stability: tready toggles 1,0,0,1 -> tdata/tlast/tuser unchanged during stalls, no beat lost or duplicated.
REQ-033 Full-with-read: FIFO full, tready=1 while an active sample arrives -> sample accepted, overflow stays 0.
REQ-034 Async reset: aresetn=0 mid-line with 3 beats queued -> tvalid=0 immediately, no beats until the next frame after a vsync trailing edge.
